// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding and the
// requester index width helper used to size grant/last-grant vectors.
// No ports.
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_HOLD      = 3'd4
   } arb_state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int req_idx_w(input int n);
      return (n > 32'sd1) ? $clog2(n) : 32'sd1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick
// Combinational round-robin picker. Searches req starting one position after
// last_grant, wrapping at N, and returns the first set bit.
//
// Ports:
//   req        in  N   request vector
//   last_grant in  IW  index that won most recently (search starts after it)
//   found      out 1   at least one request is set
//   index      out IW  winning index (0 when nothing is requested)
// -----------------------------------------------------------------------------
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = req_idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [IW-1:0] pick_s;
   logic [IW-1:0] cand_s;

   // Walk candidates from farthest to nearest so the nearest set bit overrides
   always_comb begin
      pick_s = '0;
      cand_s = '0;
      for (int off = N; off >= 1; off--) begin
         cand_s = IW'((int'(last_grant) + off) % N);
         pick_s = req[cand_s] ? cand_s : pick_s;
      end
   end

   assign found = |req;
   assign index = pick_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between N_REQ byte-stream requesters. Arbitration is
// round-robin per byte; a requester holding req_lock keeps the grant between
// bytes so multi-byte messages never interleave on the line.
//
// Optional feature: define UART_ARB_LOCK_TIMEOUT_EN to force-release a held
// lock after LOCK_TIMEOUT idle cycles in HOLD. Without it HOLD persists until
// the owner sends another byte or drops its lock.
//
// Ports:
//   clk          in   1         system clock (42 MHz domain)
//   rst          in   1         synchronous active-high reset
//   req_start    in   N_REQ     per-requester level request
//   req_data     in   8*N_REQ   byte for requester i at [8i+7:8i]
//   req_lock     in   N_REQ     keep grant after this byte
//   req_ack      out  N_REQ     one-cycle pulse, byte accepted
//   tx_start     out  1         registered start pulse to uart_tx
//   tx_data      out  8         registered byte to uart_tx (held after send)
//   tx_busy      in   1         uart_tx busy
//   grant_valid  out  1         a requester owns the UART
//   grant_id     out  GW        current owner index
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ        = 2,
   parameter int LOCK_TIMEOUT = 4200,
   parameter int TO_W         = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_start,
   input  logic [8*N_REQ-1:0]            req_data,
   input  logic [N_REQ-1:0]              req_lock,
   output logic [N_REQ-1:0]              req_ack,
   output logic                          tx_start,
   output logic [7:0]                    tx_data,
   input  logic                          tx_busy,
   output logic                          grant_valid,
   output logic [req_idx_w(N_REQ)-1:0]   grant_id
);

   localparam int GW = req_idx_w(N_REQ);

   // Reject unsupported configurations at elaboration
   if ((N_REQ < 32'sd2) || (N_REQ > 32'sd8)) begin : g_bad_n_req
      $error("uart_tx_arbiter: N_REQ must be in 2..8");
   end
   if ((LOCK_TIMEOUT < 32'sd1) || (longint'(LOCK_TIMEOUT) >= (64'sd1 <<< TO_W))) begin : g_bad_timeout
      $error("uart_tx_arbiter: LOCK_TIMEOUT must be in 1..2^TO_W-1");
   end

   arb_state_e         state_r, state_s;
   logic [GW-1:0]      grant_id_r, grant_id_s;
   logic               grant_valid_r, grant_valid_s;
   logic [GW-1:0]      last_grant_r, last_grant_s;
   logic               tx_start_r, tx_start_s;
   logic [7:0]         tx_data_r, tx_data_s;
   logic [N_REQ-1:0]   req_ack_r, req_ack_s;

   logic               pick_found_s;
   logic [GW-1:0]      pick_idx_s;
   logic               cur_start_s;
   logic               cur_lock_s;
   logic [7:0]         cur_data_s;

`ifdef UART_ARB_LOCK_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(LOCK_TIMEOUT);
   logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
`endif

   uart_tx_arbiter_rr_pick #(
      .N  (N_REQ),
      .IW (GW)
   ) u_rr_pick (
      .req        (req_start),
      .last_grant (last_grant_r),
      .found      (pick_found_s),
      .index      (pick_idx_s)
   );

   // View of the current owner's request, lock and byte
   always_comb begin
      cur_start_s = req_start[grant_id_r];
      cur_lock_s  = req_lock[grant_id_r];
      cur_data_s  = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         cur_data_s = (grant_id_r == GW'(i)) ? req_data[8*i +: 8] : cur_data_s;
      end
   end

   // Next-state and next-output logic for the arbitration FSM
   always_comb begin
      state_s       = state_r;
      grant_id_s    = grant_id_r;
      grant_valid_s = grant_valid_r;
      last_grant_s  = last_grant_r;
      tx_start_s    = 1'b0;
      tx_data_s     = tx_data_r;
      req_ack_s     = '0;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
      to_cnt_s      = to_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) begin
               grant_id_s    = pick_idx_s;
               grant_valid_s = 1'b1;
               state_s       = ST_ISSUE;
            end else begin
               state_s       = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!cur_start_s) begin
               // Withdrawn before acceptance: nothing sent, fairness pointer untouched
               grant_valid_s = 1'b0;
               state_s       = ST_IDLE;
            end else if (!tx_busy) begin
               tx_start_s             = 1'b1;
               tx_data_s              = cur_data_s;
               req_ack_s[grant_id_r]  = 1'b1;
               state_s                = ST_WAIT_BUSY;
            end else begin
               state_s       = ST_ISSUE;
            end
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_s = ST_WAIT_DONE;
            end else begin
               state_s = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (cur_lock_s) begin
                  state_s  = ST_HOLD;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
                  to_cnt_s = '0;
`endif
               end else begin
                  last_grant_s  = grant_id_r;
                  grant_valid_s = 1'b0;
                  state_s       = ST_IDLE;
               end
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         ST_HOLD: begin
            // A new byte wins over a lock drop in the same cycle
            if (cur_start_s) begin
               state_s = ST_ISSUE;
            end else if (!cur_lock_s) begin
               last_grant_s  = grant_id_r;
               grant_valid_s = 1'b0;
               state_s       = ST_IDLE;
            end else begin
`ifdef UART_ARB_LOCK_TIMEOUT_EN
               to_cnt_s = to_cnt_r + TO_W'(1'b1);
               if (to_cnt_s == TO_LIMIT) begin
                  last_grant_s  = grant_id_r;
                  grant_valid_s = 1'b0;
                  state_s       = ST_IDLE;
               end else begin
                  state_s       = ST_HOLD;
               end
`else
               state_s = ST_HOLD;
`endif
            end
         end
         default: begin
            grant_valid_s = 1'b0;
            state_s       = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         grant_id_r    <= '0;
         grant_valid_r <= 1'b0;
         last_grant_r  <= GW'(N_REQ - 1);
         tx_start_r    <= 1'b0;
         tx_data_r     <= 8'h00;
         req_ack_r     <= '0;
      end else begin
         state_r       <= state_s;
         grant_id_r    <= grant_id_s;
         grant_valid_r <= grant_valid_s;
         last_grant_r  <= last_grant_s;
         tx_start_r    <= tx_start_s;
         tx_data_r     <= tx_data_s;
         req_ack_r     <= req_ack_s;
      end
   end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
   // Idle-cycle counter for a held lock
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_r <= '0;
      end else begin
         to_cnt_r <= to_cnt_s;
      end
   end
`endif

   assign req_ack     = req_ack_r;
   assign tx_start    = tx_start_r;
   assign tx_data     = tx_data_r;
   assign grant_valid = grant_valid_r;
   assign grant_id    = grant_id_r;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between N byte-stream requesters, e.g. gamepad_sender and a debug/status sender on the 42 MHz domain. Arbitration is round-robin per byte. A requester may assert a lock to keep the grant for a multi-byte message, such as a full hex line, so messages never interleave on TX. The block sits between the requesters and uart_tx and drives the uart_tx tx_start/tx_data inputs.

Parameters:
N_REQ, 2, number of requesters (2..8)
LOCK_TIMEOUT, 4200, cycles in HOLD without a new byte before a held lock is force-released (only with UART_ARB_LOCK_TIMEOUT_EN)
TO_W, 16, width of the lock-timeout counter; must satisfy LOCK_TIMEOUT < 2^TO_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_start  in  N_REQ  per-requester level request; held high with data stable until req_ack
req_data  in  8*N_REQ  byte for requester i at [8i+7:8i]
req_lock  in  N_REQ  hold grant after current byte for next byte of same message
req_ack  out  N_REQ  one-cycle pulse: byte accepted, requester may change data or drop start
tx_start  out  1  registered one-cycle start pulse to uart_tx
tx_data  out  8  registered byte to uart_tx, stable from the tx_start cycle until the next issue
tx_busy  in  1  uart_tx busy
grant_valid  out  1  a requester currently owns the UART
grant_id  out  $clog2(N_REQ) (min 1)  current owner index

Behaviour:
- Reset values: all outputs 0. State IDLE. last_grant = N_REQ-1, so requester 0 wins the first tie. Timeout counter 0.
- IDLE:
  - If any req_start: search from last_grant+1 with wrap; first set bit wins.
  - Set grant_id, grant_valid=1, go ISSUE. Arbitration takes 1 cycle.
- ISSUE:
  - If req_start[grant]=0 (request withdrawn): release and go IDLE with no byte sent. last_grant unchanged.
  - Else if tx_busy=0: next cycle tx_start=1, tx_data=req_data[grant], req_ack[grant]=1 (same cycle); go WAIT_BUSY.
  - Else stay in ISSUE.
- WAIT_BUSY: wait for tx_busy=1, then go WAIT_DONE. tx_start is already back to 0.
- WAIT_DONE: on tx_busy=0:
  - If req_lock[grant]=1: go HOLD, clear timeout counter.
  - Else: last_grant=grant, grant_valid=0, go IDLE.
- HOLD (grant kept, other requesters blocked):
  - If req_start[grant]: go ISSUE.
  - Else if req_lock[grant]=0: release (last_grant=grant, grant_valid=0) and go IDLE.
  - Else increment timeout counter (see optional feature).
- Priority in HOLD: start beats lock-drop in the same cycle, so the byte is sent.
- Latency: IDLE request to tx_start is 2 cycles when tx_busy=0.
- Back-to-back locked bytes: tx_start spacing is the UART frame time plus 3 cycles.
- Fairness: an unlocked requester cannot send two consecutive bytes while another requester is waiting.
- Requests from non-granted requesters are ignored, never acked and never lost. They remain pending because req_start is a level.
- Requester rules:
  - req_data[i] must be stable while req_start[i]=1 and before req_ack[i].
  - req_start[i] is sampled as 0 in the cycle after req_ack unless the requester has another byte.
- Synchronous reset mid-byte:
  - The in-flight UART byte completes in uart_tx.
  - The arbiter returns to IDLE; grant and ack are lost.
  - Requesters are reset by the same rst.
- tx_data holds the last byte after the send; it is not cleared.

Optional Feature:
Macro UART_ARB_LOCK_TIMEOUT_EN.
- Defined: in HOLD, the counter increments each cycle without req_start[grant]. On reaching LOCK_TIMEOUT the grant is force-released exactly as a lock drop (last_grant=grant, IDLE). The counter clears on entering HOLD.
- Not defined: no counter exists. HOLD persists until req_start or the lock drops.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_HOLD (3-bit).
  - the requester index width function.
- One sub-module: rr_pick. It is combinational: given req vector and last_grant it returns found and index; it is reusable for other arbiters.
- The FSM, output registers and timeout counter stay in the top module.

Test Plan:
- Single request, N_REQ=2, uart_tx model:
  - Stimulus: req_start[0]=1 with data 0x41 at cycle 10, tx_busy=0.
  - Expected: tx_start at cycle 12 with tx_data=0x41; req_ack[0] at cycle 12.
- Round-robin contention:
  - Stimulus: req_start=2'b11, unlocked, data 0x30/0x31, held for 4 bytes each.
  - Expected: TX byte order 0x30,0x31,0x30,0x31…
- Lock:
  - Stimulus: req0 locks and sends "1234\n" (5 bytes) while req1 requests 0x58 from the start.
  - Expected: 0x58 appears only after 0x0A and after req_lock[0] drops.
- Withdrawal:
  - Stimulus: req1 asserts start, then drops it while tx_busy=1 in ISSUE.
  - Expected: no tx_start, no ack; IDLE within 1 cycle.
- Timeout (macro defined, LOCK_TIMEOUT=20):
  - Stimulus: req0 sends 1 locked byte then idles with lock high; req1 pending.
  - Expected: req1's byte issues 20 cycles after HOLD entry plus 2.
  - Without the macro: req1 never issues.
- Reset mid-byte:
  - Stimulus: rst for 1 cycle in WAIT_DONE.
  - Expected: all outputs 0 the next cycle; the pending requester is re-granted after tx_busy falls.
